key_event_decoder: RTL and testbench
====================================

// Module: key_event_decoder
// PURPOSE
//  Consumes a clean (synchronised, debounced) key level and decodes it into
//  single-cycle events: press, release, long-press and auto-repeat, plus a held level.
//  Sits between the key debouncer and user logic (FSMs, counters) that need
//  one pulse per action rather than a level.
// PARAMETERS
//  NBITS          24              width of the hold counter
//  PRESS_LEVEL    1'b1            key_i value meaning "pressed"
//  LONG_CYCLES    24'd20_000_000  cycles from press_o to long_o; legal range 2..2^NBITS-1
//  REPEAT_CYCLES  24'd5_000_000   cycles between long_o/repeat_o pulses; legal range 1..2^NBITS-1
//  REPEAT_EN      1               1: repeat_o active in LONG; 0: repeat_o tied low
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst_n      in   1  asynchronous active-low reset
//  key_i      in   1  debounced key level, already synchronous to clk
//  press_o    out  1  1-cycle pulse on accepted press
//  release_o  out  1  1-cycle pulse on release after an accepted press
//  long_o     out  1  1-cycle pulse when the hold reaches LONG_CYCLES
//  repeat_o   out  1  1-cycle pulse every REPEAT_CYCLES while in LONG
//  held_o     out  1  high while in PRESSED or LONG
// BEHAVIOUR
//  - All outputs registered. rst_n=0 forces, asynchronously: state=WAIT_REL,
//    cnt=0, all outputs 0. Reset during a hold emits no release_o.
//  - Define pressed = (key_i == PRESS_LEVEL), sampled at each posedge clk.
//  - Each event pulse is high for exactly one cycle, in the cycle after the edge that causes it.
//  - States and transitions, evaluated at each edge:
//    WAIT_REL: !pressed -> IDLE. Stay otherwise.
//      This blocks a spurious press when the key is held through reset.
//    IDLE:     pressed  -> PRESSED, cnt<=0, press_o<=1.
//    PRESSED:  !pressed -> IDLE, release_o<=1, cnt<=0.
//              else if cnt==LONG_CYCLES-1 -> LONG, long_o<=1, cnt<=0.
//              else cnt<=cnt+1.
//    LONG:     !pressed -> IDLE, release_o<=1, cnt<=0.
//              else if REPEAT_EN && cnt==REPEAT_CYCLES-1 -> repeat_o<=1, cnt<=0.
//              else cnt<=cnt+1 (saturates at all-ones when REPEAT_EN=0).
//  - Timing: long_o is exactly LONG_CYCLES cycles after press_o. The first
//    repeat_o is exactly REPEAT_CYCLES cycles after long_o; later ones follow at that period.
//  - Simultaneous events: a release on the same edge as a terminal count wins.
//    release_o fires; long_o and repeat_o do not.
//  - At most one of press_o, release_o, long_o, repeat_o is high in any cycle.
//  - held_o=1 in the cycle press_o is high; held_o=0 in the cycle release_o is high.
//  - Press shorter than LONG_CYCLES: output is press_o then release_o only.
//  - Once in IDLE, a press needs a single pressed sample; key_i is assumed already debounced.
// TESTING (bench params: LONG_CYCLES=8, REPEAT_CYCLES=4, PRESS_LEVEL=1)
//  1. Hold key_i=1 through reset release for 20 cycles, then 0 -> no press_o;
//     state leaves WAIT_REL; a later press gives press_o.
//  2. key_i=1 for 3 cycles, then 0 -> press_o 1 cycle after the rising sample,
//     release_o 3 cycles later, long_o never; held_o high 3 cycles.
//  3. Hold key_i=1 for 30 cycles -> press_o at t, long_o at t+8,
//     repeat_o at t+12, t+16, t+20, ...; release_o after the falling sample.
//  4. Release on the edge where cnt==7 in PRESSED -> release_o=1, long_o stays 0,
//     state IDLE.
//  5. REPEAT_EN=0, hold 40 cycles -> long_o once at t+8, repeat_o never high,
//     single release_o.
//  6. Assert rst_n=0 in LONG mid-hold -> all outputs 0 immediately (async),
//     no release_o; after rst_n=1 with the key held, no press_o until a release.

Source files
------------

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into one-cycle press/release/long/repeat pulses plus a held level.
// A key held through reset must be released before any press is accepted.
module key_event_decoder #(
   parameter int unsigned          NBITS         = 24,
   parameter logic                 PRESS_LEVEL   = 1'b1,
   parameter logic [NBITS-1:0]     LONG_CYCLES   = 24'd20_000_000,
   parameter logic [NBITS-1:0]     REPEAT_CYCLES = 24'd5_000_000,
   parameter bit                   REPEAT_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic repeat_o,
   output logic held_o
);

   typedef enum logic [1:0] {StWaitRel, StIdle, StPressed, StLong} state_t;

   localparam logic [NBITS-1:0] LongLast   = LONG_CYCLES - NBITS'(1);
   localparam logic [NBITS-1:0] RepeatLast = REPEAT_CYCLES - NBITS'(1);

   state_t           r_state;
   logic [NBITS-1:0] r_cnt;
   logic             r_press;
   logic             r_release;
   logic             r_long;
   logic             r_repeat;
   logic             r_held;
   logic             w_pressed;

   assign w_pressed = (key_i == PRESS_LEVEL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StWaitRel;
         r_cnt     <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
         r_held    <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
         case (r_state)
            StWaitRel: begin
               r_held <= 1'b0;
               if (!w_pressed) r_state <= StIdle;
            end
            StIdle: begin
               if (w_pressed) begin
                  r_state <= StPressed;
                  r_cnt   <= '0;
                  r_press <= 1'b1;
                  r_held  <= 1'b1;
               end else begin
                  r_held  <= 1'b0;
               end
            end
            StPressed: begin
               // Release takes priority over a terminal count on the same edge.
               if (!w_pressed) begin
                  r_state   <= StIdle;
                  r_release <= 1'b1;
                  r_held    <= 1'b0;
                  r_cnt     <= '0;
               end else if (r_cnt == LongLast) begin
                  r_state <= StLong;
                  r_long  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt + NBITS'(1);
               end
            end
            StLong: begin
               if (!w_pressed) begin
                  r_state   <= StIdle;
                  r_release <= 1'b1;
                  r_held    <= 1'b0;
                  r_cnt     <= '0;
               end else if (REPEAT_EN && (r_cnt == RepeatLast)) begin
                  r_repeat <= 1'b1;
                  r_cnt    <= '0;
               end else if (r_cnt != '1) begin
                  r_cnt    <= r_cnt + NBITS'(1);
               end
            end
            default: begin
               r_state <= StWaitRel;
               r_cnt   <= '0;
               r_held  <= 1'b0;
            end
         endcase
      end
   end

   assign press_o   = r_press;
   assign release_o = r_release;
   assign long_o    = r_long;
   assign repeat_o  = r_repeat;
   assign held_o    = r_held;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench: two decoders (repeat on/off) share one key; expected output vectors are
// derived from the event timing rules and queued as each key sample is driven.
module tb_key_event_decoder;

   localparam int LongN = 8;
   localparam int RepN  = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic key_i;
   logic p1, r1, l1, rp1, h1;
   logic p2, r2, l2, rp2, h2;
   logic [9:0] w_obs;

   int n_vec = 0;
   int n_err = 0;
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   key_event_decoder #(
      .LONG_CYCLES   (24'd8),
      .REPEAT_CYCLES (24'd4),
      .PRESS_LEVEL   (1'b1),
      .REPEAT_EN     (1'b1)
   ) dut_rep (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_i     (key_i),
      .press_o   (p1),
      .release_o (r1),
      .long_o    (l1),
      .repeat_o  (rp1),
      .held_o    (h1)
   );

   key_event_decoder #(
      .LONG_CYCLES   (24'd8),
      .REPEAT_CYCLES (24'd4),
      .PRESS_LEVEL   (1'b1),
      .REPEAT_EN     (1'b0)
   ) dut_norep (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_i     (key_i),
      .press_o   (p2),
      .release_o (r2),
      .long_o    (l2),
      .repeat_o  (rp2),
      .held_o    (h2)
   );

   assign w_obs = {p1, r1, l1, rp1, h1, p2, r2, l2, rp2, h2};

   task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (press,rel,long,rep,held x2)", tag, got, exp);
      end
   endtask

   // Expected {press,release,long,repeat,held} after sample i of a hold lasting n samples.
   function automatic logic [4:0] ev(input int i, input int n, input bit repen);
      logic [4:0] v;
      v = '0;
      if (i < n) begin
         v[4] = (i == 0);
         v[2] = (i == LongN);
         v[1] = repen && (i > LongN) && (((i - LongN) % RepN) == 0);
         v[0] = 1'b1;
      end else begin
         v[3] = 1'b1;
      end
      return v;
   endfunction

   always @(posedge clk) begin
      #2;
      if (exp_q.size() > 0) check_eq("cycle", w_obs, exp_q.pop_front());
   end

   task automatic step(input logic k, input logic [9:0] exp);
      @(negedge clk);
      key_i = k;
      exp_q.push_back(exp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   task automatic hold(input int n);
      for (int i = 0; i <= n; i++) step(i < n, {ev(i, n, 1'b1), ev(i, n, 1'b0)});
   endtask

   task automatic drain();
      @(posedge clk);
      #3;
      if (exp_q.size() != 0) check_eq("drain", 10'(exp_q.size()), '0);
   endtask

   initial begin
      rst_n = 1'b0;
      key_i = 1'b1;
      #23;
      check_eq("reset_state", w_obs, '0);

      // 1: key held through reset release, no press until released
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b1, '0);
      idle(2);
      hold(3);
      idle(2);

      // 2: short press
      hold(3);
      idle(3);

      // 3: long hold with repeats
      hold(30);
      idle(2);

      // 4: release exactly on the long terminal count, then immediate re-press from IDLE
      hold(8);
      hold(2);
      idle(2);

      // 5: long hold where the no-repeat instance must stay quiet
      hold(40);
      idle(2);

      // 6: asynchronous reset while in LONG
      for (int i = 0; i < 11; i++) step(1'b1, {ev(i, 1000, 1'b1), ev(i, 1000, 1'b0)});
      drain();
      check_eq("pre_reset_held", w_obs, 10'b00001_00001);
      rst_n = 1'b0;
      #1;
      check_eq("async_reset", w_obs, '0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("in_reset", w_obs, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b1, '0);
      idle(2);
      hold(2);
      idle(2);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
